// File: rtl/mux_pg_pkg.sv
// Shared types and helpers for the 2:1 mux pattern generator / self-check block.
package mux_pg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;

  // Golden 2:1 mux response for vector {s,b,a}.
  function automatic logic exp_f(input logic [2:0] idx);
    return idx[2] ? idx[1] : idx[0];
  endfunction

endpackage

// File: rtl/mux_pg_checker.sv
// Compares the sampled mux output against the golden value and keeps the
// saturating mismatch count plus the sticky first-failure record.
module mux_pg_checker
  import mux_pg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             strobe,
  input  logic             f,
  input  logic             exp,
  input  logic [2:0]       idx,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic [2:0]       first_fail_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_cnt        <= '0;
      fail           <= 1'b0;
      first_fail_idx <= 3'd0;
    end else if (strobe && (f != exp)) begin
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + 1'b1;
      end
      // Only the first mismatch of a run is recorded.
      if (!fail) begin
        fail           <= 1'b1;
        first_fail_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/mux_pattern_gen.sv
// Walks all {s,b,a} vectors into a 2:1 mux, holding each for HOLD_CYCLES,
// and checks the mux output on the last hold cycle of every vector.
module mux_pattern_gen
  import mux_pg_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int REPEAT      = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f,
  output logic             a,
  output logic             b,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail,
  output logic [2:0]       first_fail_idx
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("mux_pattern_gen: HOLD_CYCLES must be in 2..255");
  end
  if (REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
    $error("mux_pattern_gen: REPEAT must be in 1..15");
  end

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] PASS_LAST = 4'(REPEAT - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_VEC - 1);

  state_t     state_reg, state_next;
  logic [7:0] hold_reg, hold_next;
  logic [2:0] idx_reg, idx_next;
  logic [3:0] pass_reg, pass_next;
  logic [2:0] vec_reg, vec_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  logic last_hold;
  logic run_start;
  logic cmp_strobe;

  assign last_hold  = (hold_reg == HOLD_LAST);
  assign run_start  = (state_reg == IDLE) && start && !abort;
  assign cmp_strobe = (state_reg == DRIVE) && last_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      hold_reg  <= 8'd0;
      idx_reg   <= 3'd0;
      pass_reg  <= 4'd0;
      vec_reg   <= 3'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      idx_reg   <= idx_next;
      pass_reg  <= pass_next;
      vec_reg   <= vec_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // vec_next is the {s,b,a} value that will be on the pins next cycle.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    idx_next   = idx_reg;
    pass_next  = pass_reg;
    vec_next   = 3'd0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run_start) begin
          state_next = DRIVE;
          hold_next  = 8'd0;
          idx_next   = 3'd0;
          pass_next  = 4'd0;
          busy_next  = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!last_hold) begin
          hold_next = hold_reg + 8'd1;
          vec_next  = idx_reg;
          busy_next = 1'b1;
        end else if (idx_reg != IDX_LAST) begin
          hold_next = 8'd0;
          idx_next  = idx_reg + 3'd1;
          vec_next  = idx_reg + 3'd1;
          busy_next = 1'b1;
        end else if (pass_reg != PASS_LAST) begin
          hold_next = 8'd0;
          idx_next  = 3'd0;
          pass_next = pass_reg + 4'd1;
          busy_next = 1'b1;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign a    = vec_reg[0];
  assign b    = vec_reg[1];
  assign s    = vec_reg[2];
  assign busy = busy_reg;
  assign done = done_reg;

  mux_pg_checker #(
    .CNT_W(CNT_W)
  ) u_checker (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (run_start),
    .strobe         (cmp_strobe),
    .f              (f),
    .exp            (exp_f(idx_reg)),
    .idx            (idx_reg),
    .err_cnt        (err_cnt),
    .fail           (fail),
    .first_fail_idx (first_fail_idx)
  );

endmodule

// File: tb/tb_mux_pattern_gen.sv
// Directed bench for mux_pattern_gen: three instances cover the golden /
// faulty-mux, multi-pass and narrow saturating-counter configurations.
module tb_mux_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  // Instance 1: HOLD=4, REPEAT=1, CNT_W=8; f model selectable by mode1.
  int   mode1;
  logic start1, abort1, f1, a1, b1, s1, busy1, done1, fail1;
  logic [7:0] err1;
  logic [2:0] ffi1;
  assign f1 = (mode1 == 0) ? (s1 ? b1 : a1) :
              (mode1 == 1) ? 1'b0 : (s1 ? a1 : b1);

  // Instance 2: REPEAT=2, f stuck at 0.
  logic start2, abort2, a2, b2, s2, busy2, done2, fail2;
  logic f2;
  logic [7:0] err2;
  logic [2:0] ffi2;
  assign f2 = 1'b0;

  // Instance 3: REPEAT=2, CNT_W=2, f stuck at 0.
  logic start3, abort3, a3, b3, s3, busy3, done3, fail3;
  logic f3;
  logic [1:0] err3;
  logic [2:0] ffi3;
  assign f3 = 1'b0;

  mux_pattern_gen #(.HOLD_CYCLES(4), .REPEAT(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
    .a(a1), .b(b1), .s(s1), .busy(busy1), .done(done1),
    .err_cnt(err1), .fail(fail1), .first_fail_idx(ffi1));

  mux_pattern_gen #(.HOLD_CYCLES(4), .REPEAT(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .f(f2),
    .a(a2), .b(b2), .s(s2), .busy(busy2), .done(done2),
    .err_cnt(err2), .fail(fail2), .first_fail_idx(ffi2));

  mux_pattern_gen #(.HOLD_CYCLES(4), .REPEAT(2), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f(f3),
    .a(a3), .b(b3), .s(s3), .busy(busy3), .done(done3),
    .err_cnt(err3), .fail(fail3), .first_fail_idx(ffi3));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input int u);
    case (u)
      1: start1 = 1'b1;
      2: start2 = 1'b1;
      default: start3 = 1'b1;
    endcase
    step();
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  // Counts busy cycles until done is seen; stops at the done cycle.
  task automatic wait_done(input int u, output int nbusy, output logic seen);
    logic bz, dn;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      case (u)
        1: begin bz = busy1; dn = done1; end
        2: begin bz = busy2; dn = done2; end
        default: begin bz = busy3; dn = done3; end
      endcase
      if (dn) seen = 1'b1;
      else begin
        if (bz) nbusy++;
        step();
      end
    end
  endtask

  initial begin
    int   nb;
    logic seen;
    logic any;

    rst_n = 1'b0;
    mode1 = 0;
    start1 = 0; start2 = 0; start3 = 0;
    abort1 = 0; abort2 = 0; abort3 = 0;
    repeat (3) step();
    chk("reset_dut1", {29'd0, busy1, done1, s1} | {24'd0, err1} | {29'd0, ffi1} | {31'd0, fail1 | a1 | b1}, 32'd0);
    chk("reset_dut3", {27'd0, busy3, done3, err3, fail3}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: golden mux walk
    mode1 = 0;
    pulse_start(1);
    nb = 0;
    for (int k = 0; k < 32; k++) begin
      if (k % 4 == 0 || k % 4 == 3)
        chk($sformatf("t1_vec_k%0d", k), {28'd0, busy1, s1, b1, a1}, {28'd0, 1'b1, 3'(k / 4)});
      if (busy1) nb++;
      step();
    end
    chk("t1_busy_len", nb, 32);
    chk("t1_done_pulse", {29'd0, done1, busy1, a1 | b1 | s1}, 32'b100);
    step();
    chk("t1_done_once", {31'd0, done1}, 32'd0);
    chk("t1_err", {24'd0, err1}, 32'd0);
    chk("t1_fail", {31'd0, fail1}, 32'd0);

    // 2: stuck-at-0, two passes
    pulse_start(2);
    wait_done(2, nb, seen);
    chk("t2_done_seen", {31'd0, seen}, 32'd1);
    chk("t2_busy_len", nb, 64);
    chk("t2_err", {24'd0, err2}, 32'd8);
    chk("t2_fail", {31'd0, fail2}, 32'd1);
    chk("t2_ffi", {29'd0, ffi2}, 32'd1);
    step();

    // 3: inverted select
    mode1 = 2;
    pulse_start(1);
    wait_done(1, nb, seen);
    chk("t3_done_seen", {31'd0, seen}, 32'd1);
    chk("t3_busy_len", nb, 32);
    chk("t3_err", {24'd0, err1}, 32'd4);
    chk("t3_ffi", {29'd0, ffi1}, 32'd1);
    step();

    // 4: abort mid-run with inverted mux, then a clean rerun
    pulse_start(1);
    repeat (9) step();
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("t4_abort_outs", {27'd0, busy1, done1, s1, b1, a1}, 32'd0);
    chk("t4_partial_err", {24'd0, err1}, 32'd1);
    chk("t4_partial_fail", {31'd0, fail1}, 32'd1);
    any = 1'b0;
    repeat (5) begin step(); any = any | done1 | busy1; end
    chk("t4_no_done", {31'd0, any}, 32'd0);
    mode1 = 0;
    pulse_start(1);
    chk("t4_restart_clear", {23'd0, err1, fail1}, 32'd0);
    wait_done(1, nb, seen);
    chk("t4_rerun_len", nb, 32);
    chk("t4_rerun_done", {31'd0, seen}, 32'd1);
    step();

    // 5: reset mid-run, ignored start while busy
    mode1 = 2;
    pulse_start(1);
    repeat (3) step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (16) step();
    chk("t5_vec5", {29'd0, s1, b1, a1}, 32'd5);
    chk("t5_err_before", {24'd0, err1}, 32'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_reset_outs", {20'd0, busy1, done1, s1, b1, a1, fail1, ffi1} | {24'd0, err1}, 32'd0);
    any = 1'b0;
    repeat (40) begin step(); any = any | done1 | busy1; end
    chk("t5_no_second_run", {31'd0, any}, 32'd0);

    // 6: saturation with CNT_W=2, start ignored while busy and in DONE
    pulse_start(3);
    repeat (19) step();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    wait_done(3, nb, seen);
    chk("t6_remaining_len", nb, 44);
    chk("t6_done_seen", {31'd0, seen}, 32'd1);
    chk("t6_err_sat", {30'd0, err3}, 32'd3);
    chk("t6_fail_ffi", {28'd0, fail3, ffi3}, {28'd0, 1'b1, 3'd1});
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    chk("t6_start_in_done", {30'd0, busy3, done3}, 32'd0);
    step();
    chk("t6_still_idle", {31'd0, busy3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_pattern_gen.md
Name: mux_pattern_gen

Overview:
Stimulus-and-check stage that sits directly upstream of the data_level 2:1 mux, where f = s ? b : a.
- On a start request it walks every {s,b,a} combination, holding each vector for a programmable number of cycles.
- It samples the mux output f on the last hold cycle of each vector and compares it with the expected value.
- It reports a mismatch count, the first failing vector, and a done pulse, which gives an on-chip self-check for the mux.

Parameters:
HOLD_CYCLES, 4, cycles each vector is held on a/b/s; legal range 2..255; the block uses $error at elaboration if outside this range.
REPEAT, 1, number of full 8-vector passes per run; legal range 1..15.
CNT_W, 8, width of err_cnt.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge
start  input  1  one-cycle run request; ignored while busy=1
abort  input  1  cancels the current run, returns to IDLE
f  input  1  mux output under test
a  output  1  mux data input 0 (selected when s=0)
b  output  1  mux data input 1 (selected when s=1)
s  output  1  mux select
busy  output  1  high while the run is in progress
done  output  1  one-cycle pulse at run end
err_cnt  output  CNT_W  mismatches in the last or current run; saturating
fail  output  1  sticky; set on the first mismatch of a run
first_fail_idx  output  3  vector index {s,b,a} of the first mismatch

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State becomes IDLE.
  - a, b, s, busy, done, err_cnt, fail and first_fail_idx all go to 0.
  - Hold counter, vector index and pass counter clear.
  - Reset takes priority over abort and start, including mid-run.
- All outputs are registered; none depends combinationally on f, start or abort.
- Vector encoding: idx 0..7 gives a=idx[0], b=idx[1], s=idx[2]. Expected value is exp = idx[2] ? idx[1] : idx[0].
- State IDLE:
  - a=b=s=0, busy=0.
  - start=1 at edge t moves to DRIVE.
  - From edge t: busy=1, idx=0, hold_cnt=0, pass=0, err_cnt=0, fail=0, first_fail_idx=0.
  - Vector 0 is on a/b/s in the cycle after edge t.
- State DRIVE:
  - hold_cnt increments every cycle.
  - When hold_cnt==HOLD_CYCLES-1, f is compared with exp for the current idx in that same cycle.
  - On mismatch: err_cnt increments, saturating at 2^CNT_W-1. If fail was 0, fail is set to 1 and first_fail_idx is set to idx.
  - After the compare cycle:
    - If idx<7: idx increments and hold_cnt goes to 0.
    - If idx==7 and pass<REPEAT-1: pass increments, idx goes to 0, hold_cnt goes to 0.
    - Otherwise: go to DONE.
  - The mux settles within HOLD_CYCLES-1 cycles, so no compare occurs on the first cycle of a vector.
- State DONE:
  - Lasts one cycle: done=1, busy=0, a=b=s=0, then the block returns to IDLE.
  - err_cnt, fail and first_fail_idx hold their values until the next start.
- Run length: exactly 8*REPEAT*HOLD_CYCLES cycles with busy=1, followed by one done cycle.
- start while busy=1 or in DONE is ignored; it is not queued.
- abort=1 in DRIVE: the next state is IDLE, busy=0, a=b=s=0, done is not pulsed, and err_cnt/fail keep their partial values.
- abort and start high together in IDLE: abort wins and the block stays in IDLE.
- An X or Z on f is not checked; the bench guarantees f is driven.

Decomposition:
- Package mux_pg_pkg holds:
  - state enum {IDLE, DRIVE, DONE};
  - constant NUM_VEC=8;
  - function exp_f(idx) returning idx[2] ? idx[1] : idx[0].
- One natural sub-module, mux_pg_checker: takes f, exp, the compare strobe and idx, and owns err_cnt, fail and first_fail_idx, including saturation and clear-on-start.
- The sequencer (FSM plus counters) stays in the top module.

Test Plan:
1. Golden mux: connect data_level, HOLD_CYCLES=4, REPEAT=1, pulse start → busy high for 32 cycles; a/b/s step through 000..111 every 4 cycles; done pulses once; err_cnt=0, fail=0.
2. Stuck-at-0 f: tie f=0, REPEAT=2 → err_cnt=8 (idx 1,3,6,7 fail per pass); fail=1; first_fail_idx=1.
3. Inverted select: f = s ? a : b, REPEAT=1 → mismatches at idx 1,2,5,6; err_cnt=4; first_fail_idx=1.
4. Abort mid-run: start, then abort on cycle 10 → the next cycle has busy=0 and a=b=s=0, no done pulse; a following start clears err_cnt and runs a full 32 cycles.
5. Reset mid-run: rst_n=0 for one edge during vector 5 → all outputs 0 at that edge; start during the busy window before the reset is ignored, with no second run.
6. Saturation: CNT_W=2, f=0, REPEAT=2 → err_cnt holds at 3; start pulsed while busy has no effect; done occurs at cycle 64.
